mem_march_initiator: RTL and testbench



---
 rtl/mem_march_initiator_pkg.sv | 36 +++
 rtl/serial_frame_tx.sv | 52 +++++
 rtl/mem_march_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_mem_march_initiator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_march_initiator_pkg.sv
// Shared types and defaults for the march-test initiator: default widths,
// FSM state and sweep encodings, and the frame-size helpers.
package mem_march_initiator_pkg;

    localparam int DEF_ADDR_BITS   = 5;
    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_SERIAL_BITS = 2;
    localparam int DEF_TIMEOUT     = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SEND, S_POST, S_WAIT_RD, S_CHECK, S_DONE
    } march_state_e;

    // Sweep 0: write P up; sweep 1: read P / write ~P up; sweep 2: read ~P down
    typedef enum logic [1:0] {
        SWEEP_WR   = 2'd0,
        SWEEP_RDWR = 2'd1,
        SWEEP_RDDN = 2'd2
    } sweep_e;

    // Frame payload {we, addr, wdata}
    function automatic int frame_bits(input int addr_bits, input int data_bits);
        return 1 + addr_bits + data_bits;
    endfunction

    // Payload rounded up to a whole number of chunks
    function automatic int pad_bits(input int fbits, input int sbits);
        return ((fbits + sbits - 1) / sbits) * sbits;
    endfunction

    // Sweep 1 alternates read (sub=0) and write (sub=1) on each address
    function automatic logic is_write(input sweep_e sw, input logic sub);
        return (sw == SWEEP_WR) || ((sw == SWEEP_RDWR) && sub);
    endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: loads a padded command frame and shifts it out MSB-first,
// SERIAL_BITS per cycle. A load on the cycle 'last' is high chains the next
// frame with no idle gap.
module serial_frame_tx #(
    parameter int FRAME_BITS  = 14,
    parameter int SERIAL_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FRAME_BITS-1:0]  frame,
    output logic [SERIAL_BITS-1:0] tx_data,
    output logic                   tx_valid,
    output logic                   tx_start,
    output logic                   last
);
    localparam int CHUNKS = FRAME_BITS / SERIAL_BITS;
    localparam int CW     = $clog2(CHUNKS + 1);

    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;

    assign last = tx_valid && (cnt == CW'(CHUNKS - 1));

    // Chunk shifter: first chunk goes straight to the output on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_start <= 1'b0;
        end else if (load) begin
            tx_data  <= frame[FRAME_BITS-1 -: SERIAL_BITS];
            shreg    <= frame << SERIAL_BITS;
            cnt      <= '0;
            tx_valid <= 1'b1;
            tx_start <= 1'b1;
        end else if (tx_valid) begin
            tx_start <= 1'b0;
            if (last) begin
                tx_valid <= 1'b0;
                tx_data  <= '0;
            end else begin
                tx_data <= shreg[FRAME_BITS-1 -: SERIAL_BITS];
                shreg   <= shreg << SERIAL_BITS;
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_march_initiator.sv
// mem_march_initiator: on-chip march test over the serial memory protocol.
// Sweeps: write P ascending; read P then write ~P ascending; read ~P
// descending. Reports done/pass, a saturating error count and the first
// failing address. Build option WRITE_GUARD_EN: one idle cycle before and
// after every write frame (PRE/POST become real states); otherwise PRE/POST
// and the op advance are folded into the transition that leaves the
// previous state, so frames run back to back.
module mem_march_initiator
    import mem_march_initiator_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int SERIAL_BITS = DEF_SERIAL_BITS,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DATA_BITS-1:0]   pattern,
    output logic [SERIAL_BITS-1:0] tx_data,
    output logic                   tx_valid,
    output logic                   tx_start,
    input  logic [SERIAL_BITS-1:0] rx_data,
    input  logic                   rx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_count,
    output logic [ADDR_BITS-1:0]   fail_addr
);
    localparam int FRAME_BITS = frame_bits(ADDR_BITS, DATA_BITS);
    localparam int PAD_BITS   = pad_bits(FRAME_BITS, SERIAL_BITS);
    localparam int RX_CHUNKS  = DATA_BITS / SERIAL_BITS;
    localparam int RW         = $clog2(RX_CHUNKS + 1);
    localparam int TW         = $clog2(TIMEOUT + 1);
`ifdef WRITE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    march_state_e         state;
    sweep_e               sweep_q, nxt_sweep, ld_sweep;
    logic [ADDR_BITS-1:0] addr_q, nxt_addr, ld_addr;
    logic                 sub_q, nxt_sub, ld_sub, finished;
    logic [DATA_BITS-1:0] pat_q, ld_pat, ld_wdata, rd_word, exp_word;
    logic [RW-1:0]        rcnt;
    logic [TW-1:0]        tcnt;
    logic                 timed_out, chk_err;
    logic                 ld_we, cur_we, adv, enter, tx_load, tx_last;
    logic [7:0]           err_next;
    logic [PAD_BITS-1:0]  ld_frame;

    assign cur_we   = is_write(sweep_q, sub_q);
    assign exp_word = (sweep_q == SWEEP_RDWR) ? pat_q : ~pat_q;
    assign chk_err  = timed_out || (rd_word != exp_word);

    // Successor of the current op; 'finished' flags the last op of the test
    always_comb begin
        nxt_sweep = sweep_q;
        nxt_addr  = addr_q;
        nxt_sub   = 1'b0;
        finished  = 1'b0;
        case (sweep_q)
            SWEEP_WR: begin
                if (addr_q == ADDR_MAX) nxt_sweep = SWEEP_RDWR;
                nxt_addr = addr_q + 1'b1;
            end
            SWEEP_RDWR: begin
                if (!sub_q) nxt_sub = 1'b1;
                else if (addr_q == ADDR_MAX) nxt_sweep = SWEEP_RDDN;
                else nxt_addr = addr_q + 1'b1;
            end
            default: begin
                if (addr_q == '0) finished = 1'b1;
                else nxt_addr = addr_q - 1'b1;
            end
        endcase
    end

    // Frame to load: first op on start, held op in PRE, otherwise the successor
    always_comb begin
        ld_sweep = nxt_sweep;
        ld_addr  = nxt_addr;
        ld_sub   = nxt_sub;
        ld_pat   = pat_q;
        if (state == S_IDLE || state == S_DONE) begin
            ld_sweep = SWEEP_WR;
            ld_addr  = '0;
            ld_sub   = 1'b0;
            ld_pat   = pattern;
        end else if (state == S_PRE) begin
            ld_sweep = sweep_q;
            ld_addr  = addr_q;
            ld_sub   = sub_q;
        end
        ld_we    = is_write(ld_sweep, ld_sub);
        ld_wdata = !ld_we ? '0 : (ld_sweep == SWEEP_WR) ? ld_pat : ~ld_pat;
        ld_frame = PAD_BITS'({ld_we, ld_addr, ld_wdata});
    end

    // Op advance points and serializer load decision
    always_comb begin
        adv     = (state == S_SEND && tx_last && cur_we && !GUARD) ||
                  state == S_POST || state == S_CHECK;
        enter   = (start && (state == S_IDLE || state == S_DONE)) || adv;
        tx_load = (state == S_PRE) ||
                  (enter && !(adv && finished) && !(ld_we && GUARD));
    end

    // Saturating error count as it will be after this cycle
    always_comb begin
        err_next = err_count;
        if (state == S_CHECK && chk_err && err_count != 8'hFF)
            err_next = err_count + 8'd1;
    end

    serial_frame_tx #(
        .FRAME_BITS  (PAD_BITS),
        .SERIAL_BITS (SERIAL_BITS)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .frame    (ld_frame),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_start (tx_start),
        .last     (tx_last)
    );

    // Test sequencer: op tracking, response deserializer, checker, status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sweep_q   <= SWEEP_WR;
            addr_q    <= '0;
            sub_q     <= 1'b0;
            pat_q     <= '0;
            rd_word   <= '0;
            rcnt      <= '0;
            tcnt      <= '0;
            timed_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    err_count <= '0;
                    fail_addr <= '0;
                    pat_q     <= pattern;
                    sweep_q   <= SWEEP_WR;
                    addr_q    <= '0;
                    sub_q     <= 1'b0;
                    state     <= tx_load ? S_SEND : S_PRE;
                end
                S_PRE: state <= S_SEND;
                S_SEND: if (tx_last) begin
                    if (!cur_we) begin
                        state     <= S_WAIT_RD;
                        rcnt      <= '0;
                        tcnt      <= '0;
                        timed_out <= 1'b0;
                    end else if (GUARD) begin
                        state <= S_POST;
                    end
                end
                S_WAIT_RD: begin
                    // timer restarts on every chunk; a timeout drops any partial word
                    if (rx_valid) begin
                        rd_word <= (rd_word << SERIAL_BITS) | DATA_BITS'(rx_data);
                        tcnt    <= '0;
                        if (rcnt == RW'(RX_CHUNKS - 1)) state <= S_CHECK;
                        else rcnt <= rcnt + 1'b1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timed_out <= 1'b1;
                        state     <= S_CHECK;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    if (chk_err && err_count == 8'd0) fail_addr <= addr_q;
                end
                default: ;
            endcase
            if (adv) begin
                if (finished) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == 8'd0);
                end else begin
                    sweep_q <= nxt_sweep;
                    addr_q  <= nxt_addr;
                    sub_q   <= nxt_sub;
                    state   <= tx_load ? S_SEND : S_PRE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_march_initiator.sv
// Bench for mem_march_initiator (A=5, D=8, S=2, TIMEOUT=16). A behavioural
// memory decodes command frames and answers reads 3 cycles after the last
// frame chunk, with one idle cycle inside each response. Modes: 0 ideal,
// 1 bit 3 of address 7 stuck at 0, 2 never responds.
module tb_mem_march_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [1:0] tx_data;
    logic       tx_valid, tx_start;
    logic [1:0] rx_data = 2'b00;
    logic       rx_valid = 1'b0;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [4:0] fail_addr;

`ifdef WRITE_GUARD_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_march_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_start  (tx_start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          cyc = 0;
    int          mode = 0;
    logic [7:0]  mem [32];
    logic [13:0] fbuf;
    int          nch, frames, ncap, first_ts_cyc, busy_cyc;
    int          last_end_cyc, min_ww, gap, resp_wait, resp_pos, ch;
    logic        last_we, have_prev, resp_on, prev_busy;
    logic [7:0]  resp_word, d;
    logic [4:0]  a;
    logic [1:0]  cap_d [7];
    logic        cap_s [7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            nch = 0; resp_wait = 0; resp_on = 1'b0; prev_busy = 1'b0;
            rx_valid = 1'b0; rx_data = 2'b00;
        end else begin
            if (busy && !prev_busy) begin
                frames = 0; ncap = 0; min_ww = 999; have_prev = 1'b0;
                busy_cyc = cyc; first_ts_cyc = -1;
            end
            prev_busy = busy;
            rx_valid = 1'b0;
            rx_data  = 2'b00;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin resp_on = 1'b1; resp_pos = 0; end
            end
            if (resp_on) begin
                if (resp_pos != 2) begin
                    ch = (resp_pos < 2) ? resp_pos : resp_pos - 1;
                    rx_valid = 1'b1;
                    rx_data  = resp_word[7-2*ch -: 2];
                end
                resp_pos++;
                if (resp_pos == 5) resp_on = 1'b0;
            end
            if (tx_valid) begin
                if (tx_start) begin
                    nch = 0; fbuf = '0;
                    if (first_ts_cyc < 0) first_ts_cyc = cyc;
                    if (have_prev && last_we && tx_data[1]) begin
                        gap = cyc - last_end_cyc - 1;
                        if (gap < min_ww) min_ww = gap;
                    end
                end
                if (ncap < 7) begin cap_d[ncap] = tx_data; cap_s[ncap] = tx_start; ncap++; end
                fbuf = {fbuf[11:0], tx_data};
                nch++;
                if (nch == 7) begin
                    frames++;
                    last_end_cyc = cyc; last_we = fbuf[13]; have_prev = 1'b1;
                    a = fbuf[12:8]; d = fbuf[7:0];
                    if (fbuf[13]) begin
                        if (mode == 1 && a == 5'd7) d[3] = 1'b0;
                        mem[a] = d;
                    end else if (mode != 2) begin
                        resp_word = mem[a]; resp_wait = 3;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Runs one test; a second start 40 cycles in must be ignored
    task automatic run(input logic [7:0] p, input int m, output int lat);
        mode = m;
        @(negedge clk); start = 1'b1; pattern = p;
        @(negedge clk); start = 1'b0; pattern = ~p;
        check("busy_after_start", busy, 1);
        lat = -1;
        for (int i = 0; i < 8000; i++) begin
            if (done) begin lat = cyc - busy_cyc; break; end
            start = (i == 40);
            @(negedge clk);
        end
        start = 1'b0;
        check("run_done", done, 1);
        check("run_not_busy", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_fail_addr"}, fail_addr, 0);
    endtask

    initial begin
        int lat;
        int exp_lat;
        int exp_ch [7];
        exp_ch = '{2, 0, 0, 2, 2, 1, 1};
        // 64 writes gain a PRE and POST cycle each when guarded
        exp_lat = 1408 + 128 * GUARD;

        #2 rst_n = 1'b0;
        #3 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean run, also checks the first frame's encoding
        run(8'hA5, 0, lat);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("frame0_chunk%0d", i), cap_d[i], exp_ch[i]);
            check($sformatf("frame0_start%0d", i), cap_s[i], (i == 0) ? 1 : 0);
        end
        check("first_tx_start_delay", first_ts_cyc - busy_cyc, GUARD);
        check("min_write_gap", min_ww, 2 * GUARD);
        check("clean_frames", frames, 128);
        check("clean_latency", lat, exp_lat);
        check("clean_err", err_count, 0);
        check("clean_pass", pass, 1);

        // Stuck-at bit 3 on address 7
        run(8'hFF, 1, lat);
        check("stuck_frames", frames, 128);
        check("stuck_err", err_count, 1);
        check("stuck_fail_addr", fail_addr, 7);
        check("stuck_pass", pass, 0);

        // Memory silent: every read times out
        run(8'h5A, 2, lat);
        check("tmo_err", err_count, 64);
        check("tmo_fail_addr", fail_addr, 0);
        check("tmo_pass", pass, 0);

        // Reset in the middle of a sweep-1 frame, then a full clean restart
        mode = 0;
        @(negedge clk); start = 1'b1; pattern = 8'h3C;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (frames >= 40 && tx_valid && !tx_start) break;
            @(negedge clk);
        end
        check("mid_reach_sweep1", (frames >= 40 && tx_valid && !tx_start), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(8'h3C, 0, lat);
        check("restart_frames", frames, 128);
        check("restart_latency", lat, exp_lat);
        check("restart_err", err_count, 0);
        check("restart_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
